// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers feed a sliding window,
// and a 2-stage pipeline that stalls as a whole under output backpressure.
module sobel_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int MODE  = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [PIX_W-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  input  logic [PIX_W-1:0] thresh,
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof
);

  localparam int CW = $clog2(IMG_W);
  localparam int GW = PIX_W + 4;

  logic [CW-1:0]    r_col;
  logic [1:0]       r_row;
  logic [PIX_W-1:0] r_lb1 [IMG_W];
  logic [PIX_W-1:0] r_lb2 [IMG_W];
  logic [PIX_W-1:0] r_win [3][3];
  logic             r_s1_valid;
  logic             r_s1_sof;
  logic             r_s1_border;
  logic [PIX_W-1:0] r_s1_thresh;

  logic                    w_acc;
  logic [CW-1:0]           w_col;
  logic [1:0]              w_row;
  logic [PIX_W-1:0]        w_lb1_rd;
  logic [PIX_W-1:0]        w_lb2_rd;
  logic signed [GW-1:0]    w_p [3][3];
  logic signed [GW-1:0]    w_gx;
  logic signed [GW-1:0]    w_gy;
  logic [GW-1:0]           w_ax;
  logic [GW-1:0]           w_ay;
  logic [GW-1:0]           w_mag;
  logic [PIX_W-1:0]        w_sat;
  logic [PIX_W-1:0]        w_result;

  assign in_ready = !(out_valid && !out_ready);
  assign w_acc    = in_valid && in_ready;

  // An in_sof pixel restarts the frame at (0,0) whatever the counters say.
  assign w_col    = in_sof ? '0 : r_col;
  assign w_row    = in_sof ? '0 : r_row;
  assign w_lb1_rd = r_lb1[w_col];
  assign w_lb2_rd = r_lb2[w_col];

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col == CW'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (w_row == 2'd2) ? 2'd2 : w_row + 2'd1;
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // Line buffers carry no reset; stale contents only reach bordered outputs.
  always_ff @(posedge clk_clk) begin
    if (w_acc) begin
      r_lb1[w_col] <= in_data;
      r_lb2[w_col] <= w_lb1_rd;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_acc) begin
      for (int r = 0; r < 3; r++) begin
        r_win[r][0] <= r_win[r][1];
        r_win[r][1] <= r_win[r][2];
      end
      r_win[0][2] <= w_lb2_rd;
      r_win[1][2] <= w_lb1_rd;
      r_win[2][2] <= in_data;
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sof    <= 1'b0;
      r_s1_border <= 1'b1;
      r_s1_thresh <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sof    <= in_sof;
        r_s1_border <= (w_row < 2'd2) || (w_col < CW'(2));
        r_s1_thresh <= thresh;
      end
    end
  end

  // Row 0 of the window is the oldest line, column 2 the newest pixel.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_p[r][c] = $signed({4'b0000, r_win[r][c]});
      end
    end
    w_gx = (w_p[0][2] + (w_p[1][2] <<< 1) + w_p[2][2])
         - (w_p[0][0] + (w_p[1][0] <<< 1) + w_p[2][0]);
    w_gy = (w_p[2][0] + (w_p[2][1] <<< 1) + w_p[2][2])
         - (w_p[0][0] + (w_p[0][1] <<< 1) + w_p[0][2]);
    w_ax  = w_gx[GW-1] ? -w_gx : w_gx;
    w_ay  = w_gy[GW-1] ? -w_gy : w_gy;
    w_mag = w_ax + w_ay;
    w_sat = (w_mag[GW-1:PIX_W] != '0) ? '1 : w_mag[PIX_W-1:0];
    w_result = '0;
    if (!r_s1_border) begin
      if (MODE == 1) begin
        w_result = (w_sat >= r_s1_thresh) ? '1 : '0;
      end else begin
        w_result = w_sat;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
    end else if (in_ready) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_data <= w_result;
        out_sof  <= r_s1_sof;
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream: magnitude and threshold instances share
// stimulus and are scored against a whole-image Sobel reference model.
module tb_sobel_stream;

  localparam int PIX_W = 8;
  localparam int IMG_W = 8;
  localparam int MAXR  = 64;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] thresh;
  logic       out_ready;
  logic       rdy0, rdy1, ov0, ov1, os0, os1;
  logic [7:0] od0, od1;

  always #5 clk_clk = ~clk_clk;

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .MODE(0)) dutMag (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .in_data(in_data),
    .in_valid(in_valid), .in_sof(in_sof), .in_ready(rdy0), .thresh(thresh),
    .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_sof(os0));

  sobel_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .MODE(1)) dutBin (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .in_data(in_data),
    .in_valid(in_valid), .in_sof(in_sof), .in_ready(rdy1), .thresh(thresh),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_sof(os1));

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sof;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       sof;
  } act_t;

  typedef struct {
    logic [8:0][7:0] px;
    logic [7:0]      th;
    logic [7:0]      expMag;
    logic [7:0]      expBin;
  } vec_t;

  exp_t expQ[$];
  act_t actQ[$];
  vec_t vecs[$];
  int   img [MAXR][IMG_W];
  int   mrow = 0;
  int   mcol = 0;
  int   cyc = 0;
  int   nCmp = 0;
  int   nFail = 0;
  bit   checkLat = 1'b0;
  bit   randReady = 1'b0;
  bit   forceStall = 1'b0;
  bit   stallPrev = 1'b0;
  logic [7:0] holdD0, holdD1;
  logic       holdS0;

  always @(posedge clk_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int act, input int expv);
    nCmp++;
    if (act != expv) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference: keep the whole frame, apply the Sobel kernels directly to it.
  task automatic modelAccept(input int pix, input bit sof);
    int r, c, gx, gy, mag, bin;
    r = sof ? 0 : mrow;
    c = sof ? 0 : mcol;
    if (r < MAXR) img[r][c] = pix;
    if (r < 2 || c < 2 || r >= MAXR) begin
      mag = 0;
      bin = 0;
    end else begin
      gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
      gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      if (mag > 255) mag = 255;
      bin = (mag >= int'(thresh)) ? 255 : 0;
    end
    expQ.push_back('{d0: 8'(mag), d1: 8'(bin), sof: sof, cyc: cyc});
    c++;
    if (c == IMG_W) begin
      c = 0;
      r++;
    end
    mrow = r;
    mcol = c;
  endtask

  // Called and returns at posedge+1; acceptance is decided at the negedge.
  task automatic applyStimulus(input logic [7:0] d, input bit sof, input int gapMax);
    int gaps, guard;
    bit accepted;
    gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
    repeat (gaps) begin
      @(posedge clk_clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    guard    = 0;
    accepted = 1'b0;
    while (!accepted && guard < 200) begin
      @(negedge clk_clk);
      if (rdy0) begin
        accepted = 1'b1;
        modelAccept(int'(d), sof);
      end
      @(posedge clk_clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    if (!accepted) checkOutput("accept_timeout", 0, 1);
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 500) begin
      @(posedge clk_clk);
      #1;
      guard++;
    end
    checkOutput("drain_pending", expQ.size(), 0);
  endtask

  always @(negedge clk_clk) begin
    if (!reset_reset_n) begin
      stallPrev = 1'b0;
    end else begin
      checkOutput("in_ready_mag", int'(rdy0), int'(!(ov0 && !out_ready)));
      checkOutput("in_ready_bin", int'(rdy1), int'(!(ov1 && !out_ready)));
      if (stallPrev) begin
        checkOutput("stall_hold_data_mag", int'(od0), int'(holdD0));
        checkOutput("stall_hold_data_bin", int'(od1), int'(holdD1));
        checkOutput("stall_hold_sof", int'(os0), int'(holdS0));
        checkOutput("stall_hold_valid", int'(ov0), 1);
      end
      if (ov0 && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("out_data_mag", int'(od0), int'(e.d0));
          checkOutput("out_data_bin", int'(od1), int'(e.d1));
          checkOutput("out_sof_mag", int'(os0), int'(e.sof));
          checkOutput("out_sof_bin", int'(os1), int'(e.sof));
          checkOutput("out_valid_bin", int'(ov1), 1);
          if (checkLat) checkOutput("latency", cyc - e.cyc, 2);
        end
        actQ.push_back('{d0: od0, d1: od1, sof: os0});
      end
      stallPrev = ov0 && !out_ready;
      holdD0 = od0;
      holdD1 = od1;
      holdS0 = os0;
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk_clk);
      #1;
      if (forceStall)     out_ready = 1'b0;
      else if (randReady) out_ready = 1'($urandom_range(0, 1));
      else                out_ready = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base, sofs, nz;
    vec_t v;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_data  = '0;
    thresh   = '0;
    reset_reset_n = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    checkOutput("reset_valid_mag", int'(ov0), 0);
    checkOutput("reset_valid_bin", int'(ov1), 0);
    checkOutput("reset_data_mag", int'(od0), 0);
    checkOutput("reset_data_bin", int'(od1), 0);
    checkOutput("reset_sof", int'(os0), 0);
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;

    $display("[TB] flat frame");
    checkLat = 1'b1;
    thresh = 8'd50;
    base = actQ.size();
    for (int i = 0; i < 64; i++) applyStimulus(8'd100, i == 0, 0);
    waitDrain();
    checkOutput("flat_count", actQ.size() - base, 64);
    sofs = 0;
    nz = 0;
    for (int i = 0; i < 64; i++) begin
      if (actQ[base+i].sof) sofs++;
      if (actQ[base+i].d0 != 0) nz++;
    end
    checkOutput("flat_first_sof", int'(actQ[base].sof), 1);
    checkOutput("flat_sof_count", sofs, 1);
    checkOutput("flat_nonzero", nz, 0);

    $display("[TB] vertical step");
    base = actQ.size();
    for (int i = 0; i < 64; i++) applyStimulus(((i % 8) < 4) ? 8'd0 : 8'd255, i == 0, 0);
    waitDrain();
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        checkOutput($sformatf("vstep_r%0d_c%0d", r, c), int'(actQ[base+r*8+c].d0),
                    (r >= 2 && (c == 4 || c == 5)) ? 255 : 0);
      end
    end
    checkLat = 1'b0;

    $display("[TB] kernel table");
    vecs.push_back('{px: {9{8'd100}}, th: 8'd1, expMag: 8'd0, expBin: 8'd0});
    vecs.push_back('{px: {8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd255},
                     th: 8'd200, expMag: 8'd255, expBin: 8'd255});
    vecs.push_back('{px: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd20, 8'd20},
                     th: 8'd50, expMag: 8'd80, expBin: 8'd255});
    vecs.push_back('{px: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd20, 8'd20},
                     th: 8'd81, expMag: 8'd80, expBin: 8'd0});
    vecs.push_back('{px: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd20, 8'd20, 8'd20},
                     th: 8'd80, expMag: 8'd80, expBin: 8'd255});
    vecs.push_back('{px: {8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd0},
                     th: 8'd0, expMag: 8'd0, expBin: 8'd255});
    vecs.push_back('{px: {8'd10, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                     th: 8'd21, expMag: 8'd20, expBin: 8'd0});
    vecs.push_back('{px: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd30},
                     th: 8'd70, expMag: 8'd70, expBin: 8'd255});
    vecs.push_back('{px: {8'd0, 8'd10, 8'd20, 8'd0, 8'd10, 8'd20, 8'd0, 8'd10, 8'd20},
                     th: 8'd100, expMag: 8'd80, expBin: 8'd0});
    vecs.push_back('{px: {8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                     th: 8'd255, expMag: 8'd255, expBin: 8'd255});
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      thresh = v.th;
      base = actQ.size();
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < IMG_W; c++) begin
          applyStimulus((c < 3) ? v.px[8-(r*3+c)] : 8'd0, (r == 0 && c == 0), 0);
        end
      end
      waitDrain();
      checkOutput($sformatf("vec%0d_mag", k), int'(actQ[base+2*IMG_W+2].d0), int'(v.expMag));
      checkOutput($sformatf("vec%0d_bin", k), int'(actQ[base+2*IMG_W+2].d1), int'(v.expBin));
    end

    $display("[TB] random backpressure");
    randReady = 1'b1;
    thresh = 8'($urandom_range(20, 200));
    base = actQ.size();
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 64; i++) applyStimulus(8'($urandom_range(0, 255)), i == 0, 2);
    end
    waitDrain();
    checkOutput("bp_count", actQ.size() - base, 192);
    randReady = 1'b0;

    $display("[TB] mid-frame sof");
    base = actQ.size();
    for (int i = 0; i < 84; i++) applyStimulus(8'($urandom_range(1, 255)), (i == 0 || i == 20), 0);
    waitDrain();
    checkOutput("midsof_flag", int'(actQ[base+20].sof), 1);
    checkOutput("midsof_data", int'(actQ[base+20].d0), 0);
    checkOutput("midsof_col1_border", int'(actQ[base+21].d0), 0);
    checkOutput("midsof_row1_border", int'(actQ[base+20+IMG_W+4].d0), 0);

    $display("[TB] reset during stall");
    forceStall = 1'b1;
    @(posedge clk_clk);
    #1;
    @(posedge clk_clk);
    #1;
    applyStimulus(8'd77, 1'b0, 0);
    applyStimulus(8'd99, 1'b0, 0);
    repeat (3) @(posedge clk_clk);
    @(negedge clk_clk);
    checkOutput("stall_valid_before_reset", int'(ov0), 1);
    #2;
    reset_reset_n = 1'b0;
    #1;
    checkOutput("async_reset_valid_mag", int'(ov0), 0);
    checkOutput("async_reset_valid_bin", int'(ov1), 0);
    checkOutput("async_reset_data", int'(od0), 0);
    checkOutput("async_reset_sof", int'(os0), 0);
    checkOutput("async_reset_ready", int'(rdy0), 1);
    expQ.delete();
    mrow = 0;
    mcol = 0;
    repeat (2) @(posedge clk_clk);
    #1;
    forceStall = 1'b0;
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;
    base = actQ.size();
    for (int i = 0; i < 64; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1);
    waitDrain();
    checkOutput("post_reset_count", actQ.size() - base, 64);
    checkOutput("post_reset_first_border", int'(actQ[base].d0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
SOBEL_STREAM -- requirements
Module: sobel_stream

Interface
REQ-001 SHALL provide parameters, one per line (name, default, meaning):
  PIX_W  8    pixel width in bits, 4..16
  IMG_W  640  pixels per line, 4..2048; sets line-buffer depth
  MODE   0    0 = saturated magnitude output, 1 = binary threshold output
REQ-002 SHALL provide ports, one per line (name  direction  width  meaning):
  clk_clk        in   1      single clock; all logic on rising edge
  reset_reset_n  in   1      reset, asynchronous assert, active-low
  in_data        in   PIX_W  input pixel
  in_valid       in   1      in_data valid
  in_sof         in   1      first pixel of frame; qualified by in_valid
  in_ready       out  1      block accepts the input pixel
  thresh         in   PIX_W  threshold; used only when MODE=1
  out_data       out  PIX_W  edge result
  out_valid      out  1      out_data valid
  out_ready      in   1      downstream accepts the output
  out_sof        out  1      output pixel is the first of its frame
REQ-003 SHALL use clk_clk as the only clock and reset_reset_n as the only reset; reset is asynchronous, active-low.

Function
REQ-004 Accept SHALL occur on a cycle where in_valid && in_ready.
REQ-005 in_ready SHALL equal !(out_valid && !out_ready), combinationally.
REQ-006 Pipeline SHALL be 2 stages: the result for a pixel accepted in cycle T appears on out_valid/out_data in cycle T+2 if no stall occurs.
REQ-007 While out_valid && !out_ready, all stages, counters, line buffers and the window SHALL hold, and out_data/out_sof SHALL stay stable.
REQ-008 Column counter col (0..IMG_W-1) and row counter row SHALL advance once per accept; col wraps to 0 after IMG_W-1, and row increments on that wrap.
REQ-009 An accept with in_sof=1 SHALL treat that pixel as row=0, col=0, regardless of the counter state, discarding any partial frame.
REQ-010 Row saturation: row SHALL saturate at 2 and not wrap; a frame is arbitrarily tall.
REQ-011 Two line buffers, each IMG_W x PIX_W, SHALL hold the previous two rows; on each accept, the pixel at address col is read and written in cascade.
REQ-012 A 3x3 window register SHALL shift one column per accept; the newest column is {linebuf2[col], linebuf1[col], in_data}.
REQ-013 Output k SHALL correspond to window centre (row-1, col-1) of the accepted pixel; when row<2 or col<2, the result SHALL be 0 (border).
REQ-014 Gx and Gy SHALL use standard Sobel kernels, computed as signed values of PIX_W+4 bits with no overflow.
REQ-015 mag SHALL equal |Gx|+|Gy|, saturated to 2^PIX_W-1.
REQ-016 When MODE=0, out_data SHALL equal the saturated mag.
REQ-017 When MODE=1, out_data SHALL be all ones if mag >= thresh, else 0; thresh is sampled in stage 1.
REQ-018 out_sof SHALL be asserted with the output generated from the in_sof pixel.
REQ-019 Output pixel count SHALL equal accepted pixel count; there is no drop or duplication.
REQ-020 Line-buffer contents SHALL NOT need reset; the border rule (REQ-013) masks stale data.

Reset
REQ-021 While reset_reset_n=0: out_valid=0, out_data=0, out_sof=0, row=0, col=0, window=0, pipeline valids=0.
REQ-022 Reset asserted mid-frame SHALL take effect immediately, with no in-flight output emitted afterward.
REQ-023 After reset, the first accepted pixel SHALL be treated as row=0, col=0, even without in_sof.

Verification
REQ-024 Flat frame: PIX_W=8, IMG_W=8, all pixels 100, out_ready=1 -> all 64 outputs = 0, out_sof on output 1, each out_valid 2 cycles after its accept.
REQ-025 Vertical step: columns 0..3 = 0, columns 4..7 = 255, MODE=0 -> for row>=2, outputs at col 4 and col 5 = 255 (saturated from 1020), all others 0.
REQ-026 Threshold mode: MODE=1, thresh=50, horizontal step 0->20 -> mag 80 >= 50, giving 255 on the edge rows; with thresh=81 -> all 0.
REQ-027 Backpressure: out_ready random at 50% and in_valid random, 3 frames -> output stream identical to the no-stall run; in_ready low exactly when out_valid && !out_ready; out_data stable during a stall.
REQ-028 Mid-frame events: in_sof asserted at pixel 20 of a frame -> that output is 0 with out_sof=1, and the border is re-applied; reset_reset_n pulsed low during a stall -> out_valid=0 immediately, and the next frame output matches the reference model.
